// File: rtl/instr_cache_refill_ctrl.sv
// instr_cache_refill_ctrl
//   Refill engine on the memory side of the L1 instruction cache. On a miss it
//   fetches the B-aligned block that contains MissAddr, one 32-bit word per
//   memory request. It assembles the words into RepBlock and then pulses
//   RepReady for one cycle so the cache set can install the block.
//
// Ports
//   clk        clock; all state updates on the rising edge
//   reset      asynchronous active-low reset
//   CacheMiss  active cache set reports a miss
//   MissAddr   byte address of the missing fetch
//   MemReq     read request to memory, qualifies MemAddr
//   MemAddr    word-aligned read address
//   MemRValid  read data valid, one pulse per accepted request
//   MemRData   read data word
//   RepReady   block complete, single-cycle pulse
//   RepBlock   assembled block; word i occupies bits [32i+31:32i]
//   Busy       high whenever the engine is not idle
//
// state | meaning
// IDLE  | waiting for a miss
// REQ   | issue the request for word[counter]
// WAIT  | request held until MemRValid
// DONE  | block complete, RepReady high
// HOLD  | one-cycle guard so a stale miss cannot retrigger

module instr_cache_refill_ctrl #(
  parameter int B         = 64,
  parameter int AddrWidth = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 CacheMiss,
  input  logic [AddrWidth-1:0] MissAddr,
  output logic                 MemReq,
  output logic [AddrWidth-1:0] MemAddr,
  input  logic                 MemRValid,
  input  logic [31:0]          MemRData,
  output logic                 RepReady,
  output logic [B*8-1:0]       RepBlock,
  output logic                 Busy
);

  localparam int Words = B / 4;
  localparam int CntW  = $clog2(Words);
  localparam logic [CntW-1:0] LastCnt = CntW'(Words - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, HOLD} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [AddrWidth-1:0]   r_base;
  logic [CntW-1:0]        r_cnt;
  logic [B*8-1:0]         r_block;
  logic [AddrWidth-1:0]   w_miss_base;
  logic                   w_start;
  logic                   w_capture;
  logic                   w_last;

  // Clearing the offset bits keeps every request inside one aligned block,
  // so the per-word add below can never carry out of the block.
  assign w_miss_base = MissAddr & ~AddrWidth'(B - 1);
  assign w_start     = (r_state == IDLE) && CacheMiss;
  assign w_capture   = (r_state == WAIT) && MemRValid;
  assign w_last      = (r_cnt == LastCnt);

  always_comb begin
    w_next   = r_state;
    MemReq   = 1'b0;
    RepReady = 1'b0;
    Busy     = 1'b1;
    case (r_state)
      IDLE: begin
        Busy = 1'b0;
        if (CacheMiss) w_next = REQ;
      end
      REQ: begin
        MemReq = 1'b1;
        w_next = WAIT;
      end
      WAIT: begin
        MemReq = 1'b1;
        if (MemRValid) w_next = w_last ? DONE : REQ;
      end
      DONE: begin
        RepReady = 1'b1;
        w_next   = HOLD;
      end
      HOLD:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign MemAddr  = r_base + (AddrWidth'(r_cnt) << 2);
  assign RepBlock = r_block;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_base  <= '0;
      r_cnt   <= '0;
      r_block <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_base <= w_miss_base;
        r_cnt  <= '0;
      end
      // Untouched words keep stale data from the previous refill; consumers
      // only sample on RepReady, by which point every word has been rewritten.
      if (w_capture) begin
        r_block[32*r_cnt +: 32] <= MemRData;
        if (!w_last) r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_cache_refill_ctrl.sv
module tb_instr_cache_refill_ctrl;

  localparam int B     = 64;
  localparam int AW    = 32;
  localparam int WORDS = B / 4;
  localparam logic [31:0] PAT = 32'hA5A5_A5A5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          CacheMiss;
  logic [AW-1:0] MissAddr;
  logic          MemReq;
  logic [AW-1:0] MemAddr;
  logic          MemRValid;
  logic [31:0]   MemRData;
  logic          RepReady;
  logic [B*8-1:0] RepBlock;
  logic          Busy;

  always #5 clk = ~clk;

  instr_cache_refill_ctrl #(.B(B), .AddrWidth(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .CacheMiss (CacheMiss),
    .MissAddr  (MissAddr),
    .MemReq    (MemReq),
    .MemAddr   (MemAddr),
    .MemRValid (MemRValid),
    .MemRData  (MemRData),
    .RepReady  (RepReady),
    .RepBlock  (RepBlock),
    .Busy      (Busy)
  );

  int n_tests = 0;
  int n_fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // m_on     : a refill is fetching words
  // m_got    : words already delivered for this refill
  // m_fresh  : request for word m_got was issued this cycle (data not yet acceptable)
  // m_tail   : 1 = block-ready cycle, 2 = guard cycle after it
  bit          m_on = 0;
  int          m_got = 0;
  bit          m_fresh = 0;
  int          m_tail = 0;
  logic [31:0] m_base = '0;
  logic [31:0] m_blk [WORDS];

  initial begin
    foreach (m_blk[i]) m_blk[i] = '0;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_on = 0; m_got = 0; m_fresh = 0; m_tail = 0; m_base = '0;
        foreach (m_blk[i]) m_blk[i] = '0;
      end else if (m_on) begin
        if (MemRValid && !m_fresh) begin
          m_blk[m_got] = MemRData;
          m_got++;
          m_fresh = 1;
          if (m_got == WORDS) begin
            m_on   = 0;
            m_tail = 1;
          end
        end else begin
          m_fresh = 0;
        end
      end else if (m_tail == 1) begin
        m_tail = 2;
      end else if (m_tail == 2) begin
        m_tail = 0;
      end else if (CacheMiss) begin
        m_on    = 1;
        m_got   = 0;
        m_fresh = 1;
        m_base  = MissAddr & ~32'(B - 1);
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("Busy", {31'd0, Busy}, {31'd0, (m_on || m_tail != 0)});
      chk("MemReq", {31'd0, MemReq}, {31'd0, m_on});
      if (m_on) chk("MemAddr", MemAddr, m_base + 32'(4 * m_got));
      chk("RepReady", {31'd0, RepReady}, {31'd0, (m_tail == 1)});
      for (int i = 0; i < WORDS; i++)
        chk($sformatf("RepBlock[w%0d]", i), RepBlock[32*i +: 32], m_blk[i]);
    end
  end

  // ---------------- memory responder ----------------
  int max_lat    = 0;
  int spur_pct   = 0;
  int idle_req_n = 0;

  initial begin
    bit pend;
    int cnt;
    int idle_done;
    pend = 0; cnt = 0; idle_done = 0;
    MemRValid = 1'b0;
    MemRData  = '0;
    forever begin
      @(negedge clk);
      MemRValid = 1'b0;
      MemRData  = $urandom;
      if (!reset) begin
        pend = 0;
      end else if (idle_done != idle_req_n) begin
        idle_done = idle_req_n;
        MemRValid = 1'b1;
        MemRData  = 32'hBAD0_0000 | 32'($urandom_range(16'hFFFF, 0));
      end else if (pend) begin
        if (cnt == 0) begin
          MemRValid = 1'b1;
          MemRData  = MemAddr ^ PAT;
          pend      = 0;
        end else begin
          cnt--;
        end
      end else if (MemReq) begin
        pend = 1;
        cnt  = $urandom_range(max_lat, 0);
        // spurious pulse in the cycle the request is issued
        if ($urandom_range(99, 0) < spur_pct) begin
          MemRValid = 1'b1;
          MemRData  = ~(MemAddr ^ PAT);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_refill(input logic [31:0] addr, input int drop_after, input int hold_after,
                            output int n_ready, output int n_req,
                            output logic [31:0] first_a, output logic [31:0] last_a);
    int cyc;
    int since_ready;
    bit prev_req;
    logic [31:0] prev_a;
    bit done;
    cyc = 0; since_ready = -1; prev_req = 0; prev_a = '0; done = 0;
    n_ready = 0; n_req = 0; first_a = '0; last_a = '0;
    @(negedge clk);
    CacheMiss = 1'b1;
    MissAddr  = addr;
    while (!done && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (MemReq && (!prev_req || MemAddr != prev_a)) begin
        if (n_req == 0) first_a = MemAddr;
        last_a = MemAddr;
        n_req++;
      end
      prev_req = MemReq;
      prev_a   = MemAddr;
      MissAddr = $urandom;
      if (RepReady) begin
        n_ready++;
        since_ready = 0;
      end else if (since_ready >= 0) begin
        since_ready++;
      end
      if (cyc == drop_after) CacheMiss = 1'b0;
      if (since_ready >= hold_after) CacheMiss = 1'b0;
      if (n_ready > 0 && !Busy) done = 1;
    end
    CacheMiss = 1'b0;
    chk("refill_completes", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nr, nq;
    logic [31:0] fa, la, a, base;
    int budget;
    CacheMiss = 1'b0;
    MissAddr  = '0;
    repeat (3) @(negedge clk);
    chk("reset_Busy", {31'd0, Busy}, 32'd0);
    chk("reset_MemReq", {31'd0, MemReq}, 32'd0);
    chk("reset_MemAddr", MemAddr, 32'd0);
    chk("reset_RepReady", {31'd0, RepReady}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // test 1: zero extra latency
    max_lat = 0; spur_pct = 0;
    run_refill(32'h0000_1234, 0, 0, nr, nq, fa, la);
    chk("t1_ready_pulses", nr, 1);
    chk("t1_requests", nq, 16);
    chk("t1_first_addr", fa, 32'h0000_1200);
    chk("t1_last_addr", la, 32'h0000_123C);
    chk("t1_word0", RepBlock[31:0], 32'hA5A5_B7A5);
    chk("t1_word15", RepBlock[511:480], 32'hA5A5_B799);

    // test 2: random latency 0..7
    max_lat = 7;
    run_refill(32'h0000_1234, 0, 0, nr, nq, fa, la);
    chk("t2_ready_pulses", nr, 1);
    chk("t2_requests", nq, 16);
    chk("t2_word0", RepBlock[31:0], 32'hA5A5_B7A5);
    chk("t2_word15", RepBlock[511:480], 32'hA5A5_B799);

    // test 3: CacheMiss held through DONE and HOLD
    max_lat = 2;
    run_refill(32'h0000_1234, 0, 1, nr, nq, fa, la);
    chk("t3_ready_pulses", nr, 1);
    repeat (3) @(negedge clk);
    chk("t3_idle_after", {31'd0, Busy}, 32'd0);

    // test 4: async reset after the 5th word, late MemRValid, fresh refill
    max_lat = 3;
    @(negedge clk);
    CacheMiss = 1'b1;
    MissAddr  = 32'h0000_1234;
    budget = 0;
    do begin
      @(negedge clk);
      CacheMiss = 1'b0;
      budget++;
    end while (!(MemReq && MemAddr == 32'h0000_1214) && budget < 300);
    chk("t4_reach_word5", {31'd0, (budget < 300)}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t4_async_MemReq", {31'd0, MemReq}, 32'd0);
    chk("t4_async_MemAddr", MemAddr, 32'd0);
    chk("t4_async_Busy", {31'd0, Busy}, 32'd0);
    chk("t4_async_RepReady", {31'd0, RepReady}, 32'd0);
    chk("t4_async_word0", RepBlock[31:0], 32'd0);
    chk("t4_async_word4", RepBlock[159:128], 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    idle_req_n++;
    repeat (4) @(negedge clk);
    chk("t4_late_valid_Busy", {31'd0, Busy}, 32'd0);
    chk("t4_late_valid_word0", RepBlock[31:0], 32'd0);
    run_refill(32'h0000_0040, 0, 0, nr, nq, fa, la);
    chk("t4_ready_pulses", nr, 1);
    chk("t4_requests", nq, 16);
    chk("t4_first_addr", fa, 32'h0000_0040);
    chk("t4_last_addr", la, 32'h0000_007C);
    chk("t4_word0", RepBlock[31:0], 32'hA5A5_A5E5);

    // test 5: top of address space
    max_lat = 1;
    run_refill(32'hFFFF_FFF8, 0, 0, nr, nq, fa, la);
    chk("t5_first_addr", fa, 32'hFFFF_FFC0);
    chk("t5_last_addr", la, 32'hFFFF_FFFC);
    chk("t5_requests", nq, 16);
    chk("t5_word15", RepBlock[511:480], 32'h5A5A_5A59);

    // test 6: miss dropped mid-refill, spurious pulses in REQ
    max_lat = 2; spur_pct = 100;
    run_refill(32'h0000_2000, 10, 0, nr, nq, fa, la);
    chk("t6_ready_pulses", nr, 1);
    chk("t6_word0", RepBlock[31:0], 32'hA5A5_85A5);

    // random refills
    for (int k = 0; k < 12; k++) begin
      a        = $urandom;
      base     = a & ~32'(B - 1);
      max_lat  = $urandom_range(7, 0);
      spur_pct = 30;
      run_refill(a, $urandom_range(60, 0), $urandom_range(1, 0), nr, nq, fa, la);
      chk("rnd_ready_pulses", nr, 1);
      chk("rnd_requests", nq, 16);
      chk("rnd_first_addr", fa, base);
      chk("rnd_last_addr", la, base + 32'd60);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule

// File: doc/instr_cache_refill_ctrl.md
Name: instr_cache_refill_ctrl

Overview:
- Refill engine on the memory side of the L1 instruction cache.
- On a cache miss it fetches the aligned B-byte block containing the miss address from next-level memory, one 32-bit word at a time.
- It assembles the words into a full block, then presents that block with a one-cycle RepReady pulse for the cache set to install.
- It is the supplier of RepBlock/RepReady, sitting between the cache sets and the memory interface.

Parameters:
- B, 64, block size in bytes; power of two, at least 8.
- AddrWidth, 32, byte-address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- CacheMiss  in  1  high while the active cache set reports a miss.
- MissAddr  in  AddrWidth  byte address of the missing fetch (PC).
- MemReq  out  1  read request to memory for MemAddr.
- MemAddr  out  AddrWidth  word-aligned read address.
- MemRValid  in  1  read data valid; one pulse per accepted request.
- MemRData  in  32  read data word.
- RepReady  out  1  block complete; single-cycle pulse.
- RepBlock  out  B*8  assembled block; word i occupies bits [32i+31:32i].
- Busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; MemReq=0, MemAddr=0, RepReady=0, RepBlock=0, Busy=0; word counter=0. Reset asserted mid-refill abandons the refill with no RepReady pulse; a late MemRValid after release is ignored in IDLE.
- Words = B/4; the counter is log2(Words) bits wide.
- States: IDLE, REQ, WAIT, DONE, HOLD.
- IDLE:
  - On CacheMiss=1, latch BaseAddr = MissAddr with the low log2(B) bits cleared; counter=0; go to REQ.
  - CacheMiss in IDLE while RepReady=0 is the only start condition.
- REQ: MemReq=1, MemAddr = BaseAddr + 4*counter; go to WAIT next cycle.
- WAIT:
  - MemReq stays 1 and MemAddr stays stable until MemRValid.
  - On MemRValid=1: write MemRData into RepBlock word[counter] and drop MemReq that same edge.
  - If counter == Words-1, go to DONE; otherwise counter+1 and go to REQ.
  - Memory latency is unbounded; no timeout.
- DONE: RepReady=1 for exactly one cycle; RepBlock is stable and complete. Go to HOLD.
- HOLD:
  - One-cycle guard that ignores CacheMiss while the cache set updates its tags, so a stale miss cannot retrigger; then IDLE.
  - A genuine new miss seen in IDLE after HOLD starts a fresh refill; minimum miss-to-miss spacing is 2 cycles after RepReady.
- RepBlock:
  - Holds its contents after DONE until the next refill overwrites it word by word.
  - Words not yet written in the current refill keep their old values; consumers may sample only on RepReady.
- CacheMiss deasserting mid-refill (e.g. a flush or redirect) does not abort; the refill completes and RepReady still pulses, since the cache set ignores RepReady without a miss.
- MemRValid outside WAIT is ignored.
- MissAddr changing after the latch has no effect.
- Address arithmetic is modulo 2^AddrWidth; the block never crosses a B-aligned boundary because the offset is below B.
- Latency, in cycles from the CacheMiss edge to RepReady: 1 (latch) + Words*(2 + memory latency) + 1.

Test Plan:
- Reset, then a miss at MissAddr=0x0000_1234 with B=64 and memory answering 1 cycle after each MemReq (data = addr ^ 0xA5A5_A5A5) -> MemAddr steps 0x1200, 0x1204 … 0x123C (16 requests); RepReady pulses once; RepBlock word0 = 0xA5A5_B7A5, word15 = 0xA5A5_B799.
- Same miss with random memory latency of 0–7 cycles per word -> MemAddr stable while waiting, no duplicate or skipped words, RepBlock identical to the first test.
- CacheMiss held high through DONE and HOLD -> exactly one RepReady; no second refill starts until CacheMiss has been seen in IDLE.
- Reset driven low after the 5th word of a refill, then released, then a MemRValid pulse injected -> all outputs 0 immediately (asynchronous); pulse ignored; next miss at 0x40 fetches 0x40–0x7C from word 0.
- Miss at 0xFFFF_FFF8 -> base 0xFFFF_FFC0; last MemAddr 0xFFFF_FFFC; no wrap past the block.
- CacheMiss dropped mid-refill and a spurious MemRValid pulsed while in REQ -> refill completes; RepReady pulses once; the spurious data is not captured.
